// File: rtl/bram_port_master_if.sv
// Request/write/read channels plus BRAM port B pins.
// master = initiator view, slave = agent + BRAM view.
interface bram_port_master_if #(
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_NUM_WE      = 4,
  parameter int unsigned C_LEN_W       = 4
);
  logic                     Req_Valid;
  logic                     Req_Ready;
  logic                     Req_Write;
  logic [0:C_PORT_AWIDTH-1] Req_Addr;
  logic [0:C_LEN_W-1]       Req_Len;
  logic [0:C_NUM_WE-1]      Req_BE;
  logic                     Wr_Valid;
  logic                     Wr_Ready;
  logic [0:C_PORT_DWIDTH-1] Wr_Data;
  logic                     Rd_Valid;
  logic                     Rd_Ready;
  logic [0:C_PORT_DWIDTH-1] Rd_Data;
  logic                     Rd_Last;
  logic                     Addr_Err;
  logic                     BRAM_Clk;
  logic                     BRAM_Rst;
  logic                     BRAM_EN;
  logic [0:C_NUM_WE-1]      BRAM_WEN;
  logic [0:C_PORT_AWIDTH-1] BRAM_Addr;
  logic [0:C_PORT_DWIDTH-1] BRAM_Dout;
  logic [0:C_PORT_DWIDTH-1] BRAM_Din;

  modport master (
    input  Req_Valid, Req_Write, Req_Addr,
    input  Req_Len, Req_BE,
    input  Wr_Valid, Wr_Data, Rd_Ready,
    input  BRAM_Din,
    output Req_Ready, Wr_Ready,
    output Rd_Valid, Rd_Data, Rd_Last,
    output Addr_Err,
    output BRAM_Clk, BRAM_Rst, BRAM_EN,
    output BRAM_WEN, BRAM_Addr, BRAM_Dout
  );

  modport slave (
    output Req_Valid, Req_Write, Req_Addr,
    output Req_Len, Req_BE,
    output Wr_Valid, Wr_Data, Rd_Ready,
    output BRAM_Din,
    input  Req_Ready, Wr_Ready,
    input  Rd_Valid, Rd_Data, Rd_Last,
    input  Addr_Err,
    input  BRAM_Clk, BRAM_Rst, BRAM_EN,
    input  BRAM_WEN, BRAM_Addr, BRAM_Dout
  );
endinterface

// File: rtl/bram_port_master.sv
// Burst initiator for one MicroBlaze LMB BRAM port.
// Ports: Clk, Rst_N (async low), bus (master modport).
module bram_port_master #(
  parameter int unsigned C_MEMSIZE     = 'h4000,
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_NUM_WE      = 4,
  parameter int unsigned C_LEN_W       = 4
) (
  input  logic Clk,
  input  logic Rst_N,
  bram_port_master_if.master bus
);

  localparam int unsigned AW = C_PORT_AWIDTH;
  localparam int unsigned DW = C_PORT_DWIDTH;
  localparam int unsigned NW = C_NUM_WE;
  localparam int unsigned LW = C_LEN_W + 1;

  localparam logic [AW-1:0] MEMSZ = AW'(C_MEMSIZE);
  localparam logic [AW-1:0] STEP  = AW'(4);
  localparam logic [AW-1:0] OMASK =
    (MEMSZ - AW'(1)) & ~AW'(3);
  localparam logic [LW-1:0] ONE   = LW'(1);

  typedef enum logic [1:0] {
    IDLE, WR_BURST, RD_BURST, RD_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic          rdy_en_q;
  logic [AW-1:0] off_q;
  logic [LW-1:0] left_q;
  logic [NW-1:0] be_q;
  logic          err_q;
  logic          infl_q;
  logic          infl_last_q;

  logic [DW-1:0] fd_q [2];
  logic          fl_q [2];
  logic          wp_q, rp_q;
  logic [1:0]    cnt_q;

  logic          req_ready;
  logic          req_fire;
  logic          wr_beat;
  logic          rd_issue;
  logic          last_beat;
  logic          pop;
  logic          push;
  logic [2:0]    occ;

  assign req_ready = (state_q == IDLE) & rdy_en_q;
  assign req_fire  = bus.Req_Valid & req_ready;
  assign wr_beat   = (state_q == WR_BURST)
                   & bus.Wr_Valid;
  assign last_beat = (left_q == ONE);
  assign pop       = (cnt_q != 2'd0) & bus.Rd_Ready;
  assign push      = infl_q;

  // Issue only if the beat is sure to find a FIFO
  // slot: queued + in-flight, less this cycle's pop.
  assign occ      = {1'b0, cnt_q} + {2'b0, infl_q};
  assign rd_issue = (state_q == RD_BURST)
                  & (occ < (3'd2 + {2'b0, pop}));

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_fire)
          state_d = bus.Req_Write ? WR_BURST
                                  : RD_BURST;
      end
      WR_BURST: begin
        if (wr_beat && last_beat) state_d = IDLE;
      end
      RD_BURST: begin
        if (rd_issue && last_beat) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (cnt_q == 2'd0 && !infl_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Req_Ready = req_ready;
    bus.Wr_Ready  = (state_q == WR_BURST);
    bus.BRAM_EN   = wr_beat | rd_issue;
    bus.BRAM_WEN  = wr_beat ? be_q : '0;
    bus.BRAM_Addr = off_q;
    bus.BRAM_Dout = wr_beat ? bus.Wr_Data : '0;
    bus.Rd_Valid  = (cnt_q != 2'd0);
    bus.Rd_Data   = fd_q[rp_q];
    bus.Rd_Last   = fl_q[rp_q] & (cnt_q != 2'd0);
    bus.Addr_Err  = err_q;
  end

  assign bus.BRAM_Clk = Clk;
  assign bus.BRAM_Rst = ~Rst_N;

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      rdy_en_q    <= 1'b0;
      off_q       <= '0;
      left_q      <= '0;
      be_q        <= '0;
      err_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      rdy_en_q    <= 1'b1;
      err_q       <= req_fire
                   & (bus.Req_Addr >= MEMSZ);
      infl_q      <= rd_issue;
      infl_last_q <= rd_issue & last_beat;
      if (req_fire) begin
        off_q  <= bus.Req_Addr & OMASK;
        left_q <= {1'b0, bus.Req_Len} + ONE;
        be_q   <= bus.Req_BE;
      end else if (wr_beat || rd_issue) begin
        off_q  <= (off_q + STEP) & OMASK;
        left_q <= left_q - ONE;
      end
    end
  end

  // Din belongs to the beat issued last cycle.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      for (int i = 0; i < 2; i++) begin
        fd_q[i] <= '0;
        fl_q[i] <= 1'b0;
      end
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fd_q[wp_q] <= bus.BRAM_Din;
        fl_q[wp_q] <= infl_last_q;
        wp_q       <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_master.sv
// Directed bench for bram_port_master with a
// behavioural 1-cycle BRAM and a burst vector table.
module tb_bram_port_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_port_master_if bus ();

  bram_port_master dut (
    .Clk   (clk),
    .Rst_N (rst_n),
    .bus   (bus.master)
  );

  bit [31:0] mem [4096];

  always @(posedge clk) begin : bram_model
    logic [31:0] a, d, w;
    logic [3:0]  we;
    int          idx;
    if (bus.BRAM_EN) begin
      a   = bus.BRAM_Addr;
      d   = bus.BRAM_Dout;
      we  = bus.BRAM_WEN;
      idx = int'((a >> 2) & 32'hFFF);
      w   = mem[idx];
      for (int j = 0; j < 4; j++)
        if (we[j]) w[8*j +: 8] = d[8*j +: 8];
      bus.BRAM_Din <= mem[idx];
      mem[idx]     <= w;
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  be;
    logic [31:0] d0;
    logic [31:0] a0;
    bit          tog;
    bit          err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic bit rr(input int c);
    return (c % 4 == 0) || (c % 4 == 3);
  endfunction

  task automatic run_burst(input vec_t v,
                           input string tag);
    int          n;
    logic [31:0] ea [$];
    logic [3:0]  ew [$];
    logic [31:0] rd [$];
    bit          rl [$];
    int          acc_c, first_en, last_en;
    int          first_rv, err_n, err_c;
    int          wbeat, occ, viol, done_c;
    bit          acc, fin, popn;
    logic [31:0] ex;
    n = int'(v.len) + 1;
    acc = 0; fin = 0; acc_c = -1;
    first_en = -1; last_en = -1;
    first_rv = -1; err_n = 0; err_c = -1;
    wbeat = 0; occ = 0; viol = 0; done_c = -1;
    @(posedge clk); #1;
    bus.Req_Valid = 1'b1;
    bus.Req_Write = v.wr;
    bus.Req_Addr  = v.addr;
    bus.Req_Len   = v.len;
    bus.Req_BE    = v.be;
    bus.Wr_Valid  = v.wr;
    bus.Wr_Data   = v.d0;
    bus.Rd_Ready  = 1'b1;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge clk);
      if (bus.Addr_Err) begin
        err_n++;
        err_c = cyc;
      end
      if (acc && bus.Req_Ready &&
          ((v.wr && wbeat == n) ||
           (!v.wr && rd.size() == n))) begin
        fin = 1;
        done_c = cyc;
      end
      popn = bus.Rd_Valid && bus.Rd_Ready;
      if (bus.Rd_Valid && first_rv < 0)
        first_rv = cyc;
      if (bus.BRAM_EN) begin
        ea.push_back(bus.BRAM_Addr);
        ew.push_back(bus.BRAM_WEN);
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        if (!v.wr && (occ - int'(popn)) >= 2)
          viol++;
        if (!v.wr) occ++;
      end
      if (popn) begin
        rd.push_back(bus.Rd_Data);
        rl.push_back(bus.Rd_Last);
        occ--;
      end
      if (bus.Wr_Valid && bus.Wr_Ready) wbeat++;
      if (bus.Req_Valid && bus.Req_Ready) begin
        acc = 1;
        acc_c = cyc;
      end
      @(posedge clk); #1;
      if (acc) bus.Req_Valid = 1'b0;
      bus.Wr_Valid = v.wr && (wbeat < n);
      bus.Wr_Data  = v.d0 + 32'(wbeat);
      bus.Rd_Ready = v.tog ? rr(k + 1) : 1'b1;
    end
    bus.Wr_Valid = 1'b0;
    bus.Rd_Ready = 1'b1;
    chk({tag, " done"}, 32'(fin), 32'd1);
    chk({tag, " n_en"}, ea.size(), n);
    for (int i = 0; i < n && i < ea.size(); i++) begin
      ex = (v.a0 + 32'(4 * i)) & 32'h3FFC;
      chk($sformatf("%s addr%0d", tag, i), ea[i], ex);
      chk($sformatf("%s wen%0d", tag, i),
          32'(ew[i]), v.wr ? 32'(v.be) : 32'd0);
    end
    chk({tag, " en_lat"}, first_en, acc_c + 1);
    if (v.err) begin
      chk({tag, " err_n"}, err_n, 1);
      chk({tag, " err_cyc"}, err_c, acc_c + 1);
    end else begin
      chk({tag, " err_n"}, err_n, 0);
    end
    if (v.wr) begin
      chk({tag, " rdy_again"}, done_c, last_en + 1);
    end else begin
      chk({tag, " n_rd"}, rd.size(), n);
      for (int i = 0; i < n && i < rd.size(); i++) begin
        chk($sformatf("%s data%0d", tag, i),
            rd[i], v.d0 + 32'(i));
        chk($sformatf("%s last%0d", tag, i),
            32'(rl[i]), 32'(i == n - 1));
      end
      chk({tag, " rv_lat"}, first_rv, acc_c + 3);
      chk({tag, " occ"}, viol, 0);
    end
  endtask

  initial begin
    int  pops, en_bad;
    bit  acc, hit;
    bus.Req_Valid = 1'b0;
    bus.Req_Write = 1'b0;
    bus.Req_Addr  = '0;
    bus.Req_Len   = '0;
    bus.Req_BE    = '0;
    bus.Wr_Valid  = 1'b0;
    bus.Wr_Data   = '0;
    bus.Rd_Ready  = 1'b1;

    tbl[0] = '{1, 'h100,  3, 'hF, 'hA0,   'h100,  0, 0};
    tbl[1] = '{0, 'h100,  3, 'hF, 'hA0,   'h100,  0, 0};
    tbl[2] = '{0, 'h100,  3, 'hF, 'hA0,   'h100,  1, 0};
    tbl[3] = '{1, 'h3FFC, 1, 'h3, 'h11223344,
               'h3FFC, 0, 0};
    tbl[4] = '{0, 'h3FFC, 1, 'hF, 'h3344, 'h3FFC, 0, 0};
    tbl[5] = '{1, 'h4010, 0, 'hF, 'hBEEF, 'h10,   0, 1};
    tbl[6] = '{0, 'h10,   0, 'hF, 'hBEEF, 'h10,   0, 0};
    tbl[7] = '{1, 'h200,  7, 'hF, 'hC0,   'h200,  0, 0};
    tbl[8] = '{0, 'h4200, 7, 'hF, 'hC0,   'h200,  1, 1};

    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(bus.Req_Ready), 0);
    chk("rst wr_ready", 32'(bus.Wr_Ready), 0);
    chk("rst rd_valid", 32'(bus.Rd_Valid), 0);
    chk("rst rd_last", 32'(bus.Rd_Last), 0);
    chk("rst addr_err", 32'(bus.Addr_Err), 0);
    chk("rst en", 32'(bus.BRAM_EN), 0);
    chk("rst wen", 32'(bus.BRAM_WEN), 0);
    chk("rst bram_rst", 32'(bus.BRAM_Rst), 1);
    rst_n = 1'b1;
    #1;
    chk("rel ready0", 32'(bus.Req_Ready), 0);
    chk("rel bram_rst", 32'(bus.BRAM_Rst), 0);
    @(posedge clk); #1;
    chk("rel ready1", 32'(bus.Req_Ready), 1);

    for (int t = 0; t < 9; t++)
      run_burst(tbl[t], $sformatf("v%0d", t));

    // Reset while beat 2 of an 8-beat read pops.
    @(posedge clk); #1;
    bus.Req_Valid = 1'b1;
    bus.Req_Write = 1'b0;
    bus.Req_Addr  = 'h200;
    bus.Req_Len   = 4'd7;
    bus.Rd_Ready  = 1'b1;
    pops = 0; acc = 0; hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk);
      if (bus.Req_Valid && bus.Req_Ready) acc = 1;
      if (bus.Rd_Valid && bus.Rd_Ready) pops++;
      if (pops == 2) begin
        hit = 1;
      end else begin
        @(posedge clk); #1;
        if (acc) bus.Req_Valid = 1'b0;
      end
    end
    chk("mid reached", 32'(hit), 1);
    #1;
    rst_n = 1'b0;
    bus.Req_Valid = 1'b0;
    #1;
    chk("mid rd_valid", 32'(bus.Rd_Valid), 0);
    chk("mid en", 32'(bus.BRAM_EN), 0);
    chk("mid rd_last", 32'(bus.Rd_Last), 0);
    chk("mid req_ready", 32'(bus.Req_Ready), 0);
    en_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.BRAM_EN || bus.Rd_Valid) en_bad++;
    end
    chk("mid quiet", en_bad, 0);
    rst_n = 1'b1;
    #1;
    chk("mid ready0", 32'(bus.Req_Ready), 0);
    @(posedge clk); #1;
    chk("mid ready1", 32'(bus.Req_Ready), 1);
    chk("mid empty", 32'(bus.Rd_Valid), 0);
    run_burst('{0, 'h200, 7, 'hF, 'hC0, 'h200, 0, 0},
              "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_port_master.md
Name: bram_port_master

Overview:
- Initiator for one port of the MicroBlaze local BRAM block: the side that drives EN/WEN/Addr/Dout and samples Din.
- Converts a valid/ready burst request channel into BRAM port cycles.
- Returns read data through a 2-entry response FIFO so the fixed 1-cycle BRAM latency is absorbed under consumer backpressure.
- Sits between a DMA/packet-engine agent and BRAM port B.

Parameters:
- C_MEMSIZE, 'h4000: BRAM size in bytes; power of two.
- C_PORT_DWIDTH, 32: data width; fixed at 32.
- C_PORT_AWIDTH, 32: address width.
- C_NUM_WE, 4: byte write enables; C_PORT_DWIDTH/8.
- C_LEN_W, 4: burst length field width; max burst is 2**C_LEN_W beats.

Ports:
- Clk  in  1  single clock for all logic
- Rst_N  in  1  asynchronous, active-low reset
- Req_Valid  in  1  request valid
- Req_Ready  out  1  request accepted when Req_Valid & Req_Ready
- Req_Write  in  1  1 = write burst, 0 = read burst
- Req_Addr  in  [0:C_PORT_AWIDTH-1]  byte start address; low 2 bits ignored
- Req_Len  in  [0:C_LEN_W-1]  beats minus one
- Req_BE  in  [0:C_NUM_WE-1]  byte enables applied to every write beat
- Wr_Valid / Wr_Ready  in / out  1  write data handshake
- Wr_Data  in  [0:C_PORT_DWIDTH-1]  write beat data
- Rd_Valid / Rd_Ready  out / in  1  read data handshake
- Rd_Data  out  [0:C_PORT_DWIDTH-1]  read beat data
- Rd_Last  out  1  marks the final beat of a read burst
- Addr_Err  out  1  one-cycle pulse: accepted Req_Addr >= C_MEMSIZE
- BRAM_Clk  out  1  equals Clk
- BRAM_Rst  out  1  equals ~Rst_N
- BRAM_EN  out  1  port enable
- BRAM_WEN  out  [0:C_NUM_WE-1]  byte write enables
- BRAM_Addr  out  [0:C_PORT_AWIDTH-1]  word-aligned byte address
- BRAM_Dout  out  [0:C_PORT_DWIDTH-1]  data written to BRAM
- BRAM_Din  in  [0:C_PORT_DWIDTH-1]  data read from BRAM, valid the cycle after EN

Behaviour:
- Reset values (Rst_N low):
  - state IDLE; FIFO empty; counters 0.
  - Req_Ready, Wr_Ready, Rd_Valid, Rd_Last, Addr_Err, BRAM_EN all 0; BRAM_WEN 0.
  - Req_Ready rises on the first Clk edge with Rst_N high.
- Reset mid-burst: burst abandoned; no further BRAM cycles; FIFO contents discarded; no partial Rd_Last.
- Address handling:
  - offset = Req_Addr mod C_MEMSIZE, with low 2 bits cleared.
  - Each beat adds 4, wrapping modulo C_MEMSIZE (wraps at 'h3FFC to 0).
  - Addr_Err pulses in the cycle after acceptance when Req_Addr >= C_MEMSIZE; the burst still executes at the wrapped offset.
- States:
  - IDLE: Req_Ready=1. On handshake, latch offset, remaining beats (Req_Len+1) and BE, then go to WR_BURST or RD_BURST.
  - WR_BURST: Wr_Ready=1.
    - Each Wr_Valid cycle drives combinationally BRAM_EN=1, BRAM_WEN=BE, BRAM_Addr=offset, BRAM_Dout=Wr_Data; then advance offset.
    - On the final beat, go to IDLE.
    - Wr_Valid low: EN=0 and no progress.
  - RD_BURST:
    - issue = (fifo_cnt + inflight - pop) < 2, where inflight = EN in the previous cycle and pop = Rd_Valid & Rd_Ready.
    - When issue holds: BRAM_EN=1, WEN=0, Addr=offset.
    - After the last issue, go to RD_DRAIN.
  - RD_DRAIN: wait until the FIFO is empty and inflight=0, then go to IDLE.
- Read path:
  - BRAM_Din is captured into the FIFO at the end of the cycle after EN.
  - Rd_Valid = FIFO not empty. Rd_Data and Rd_Last come from the FIFO head.
  - Rd_Last is tagged on the Req_Len+1-th beat.
- Read latency: request handshake in cycle A -> first EN in A+1 -> Rd_Valid in A+3.
- Throughput: 1 beat/cycle with Rd_Ready held high.
- FIFO never overflows; it holds at most 2 entries under any Rd_Ready pattern.
- Simultaneous FIFO push and pop is allowed, and the count is unchanged.
- Writes have no response channel; write completion is the return to IDLE.

Test Plan:
- Write burst, Addr='h100, Len=3, BE=4'b1111, data 'hA0..'hA3, Wr_Valid always high -> 4 consecutive EN+WEN=1111 cycles at addresses 'h100/'h104/'h108/'h10C; Req_Ready high again on the next cycle.
- Read back, Addr='h100, Len=3, Rd_Ready=1 -> Rd_Valid first at A+3; 'hA0..'hA3 on 4 consecutive cycles; Rd_Last only with 'hA3.
- Same read with Rd_Ready toggling 1,0,0,1,... -> data in order, no loss or duplicate; never more than 2 EN cycles without a pop.
- Partial write BE=4'b0011 to 'h3FFC with Len=1 -> second beat goes to 'h0000; WEN=0011 on both beats; Addr_Err stays 0.
- Request Addr='h4010 -> Addr_Err one-cycle pulse; access goes to 'h0010.
- Rst_N low during beat 2 of an 8-beat read -> Rd_Valid and BRAM_EN go 0 immediately; Req_Ready 1 one edge after release; next read returns correct data.
